// File: rtl/oc8051_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_fetch_pkg
// Purpose : Shared types and helpers for the oc8051 instruction fetch stage.
//           Holds the fetch FSM state encoding, the default internal-ROM
//           address width and the op_len decode helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package oc8051_fetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE    = 2'd0,
    ST_ROM_WAIT = 2'd1,
    ST_EXT      = 2'd2,
    ST_VALID    = 2'd3
  } fetch_state_e;

  localparam int DEF_INT_ROM_WID = 8;

  // A zero length from the decoder still has to make forward progress.
  function automatic logic [15:0] op_len_dec(input logic [1:0] len);
    return (len == 2'd0) ? 16'd1 : {14'd0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/oc8051_ext_byte_rd.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_ext_byte_rd
// Purpose : Reads a 3-byte window from external program space one byte at a
//           time over a req/ack bus. ext_req stays high until the third ack.
//           An abort (PC reload) marks the outstanding byte for discard; the
//           bus handshake is still completed before the sequencer goes idle.
// Ports   : clk, rst (sync, active-low)
//           start, base_addr  - begin a 3-byte read at base_addr
//           abort             - drop the window (pc reload)
//           ext_req/ext_addr  - external request and byte address
//           ext_ack/ext_data  - byte accept and read data
//           byte0, byte1      - first two captured bytes
//           done              - third byte accepted this cycle (ext_data valid)
//           drop              - ack consumed while the window was abandoned
// Revision: 1.0 - initial release
// ============================================================================
module oc8051_ext_byte_rd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        abort,
  output logic        ext_req,
  output logic [15:0] ext_addr,
  input  logic        ext_ack,
  input  logic [7:0]  ext_data,
  output logic [7:0]  byte0,
  output logic [7:0]  byte1,
  output logic        done,
  output logic        drop
);

  logic [1:0]  r_idx;
  logic        r_discard;
  logic        r_req;
  logic [15:0] r_addr;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;

  logic w_ack;
  logic w_kill;

  assign w_ack  = r_req && ext_ack;
  assign w_kill = r_discard || abort;
  assign done   = w_ack && !w_kill && (r_idx == 2'd2);
  assign drop   = w_ack && w_kill;

  assign ext_req  = r_req;
  assign ext_addr = r_addr;
  assign byte0    = r_b0;
  assign byte1    = r_b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx     <= 2'd0;
      r_discard <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= 16'h0000;
      r_b0      <= 8'h00;
      r_b1      <= 8'h00;
    end else if (start) begin
      r_idx     <= 2'd0;
      r_discard <= 1'b0;
      r_req     <= 1'b1;
      r_addr    <= base_addr;
    end else if (w_ack) begin
      if (w_kill) begin
        // Abandoned window: finish the handshake, keep nothing.
        r_req     <= 1'b0;
        r_discard <= 1'b0;
      end else begin
        r_addr <= r_addr + 16'd1;
        case (r_idx)
          2'd0:    r_b0 <= ext_data;
          2'd1:    r_b1 <= ext_data;
          default: ;
        endcase
        if (r_idx == 2'd2) begin
          r_req <= 1'b0;
          r_idx <= 2'd0;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
    end else if (r_req && abort) begin
      // Request already on the bus cannot be withdrawn; remember to drop it.
      r_discard <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/oc8051_op_fetch.sv
`default_nettype none
// ============================================================================
// Module  : oc8051_op_fetch
// Purpose : Instruction fetch stage between oc8051_rom and the decoder. Keeps
//           the PC, reads a 3-byte opcode window from internal ROM (registered,
//           1-cycle latency) or from external program space via req/ack, and
//           advances the PC by the length the decoder consumes.
// Ports   : clk, rst (sync, active-low)
//           rom_addr/rom_ea_int/rom_data1..3 - internal ROM interface
//           ext_req/ext_addr/ext_ack/ext_data - external byte bus
//           pc_load/pc_in                    - PC reload (jump/irq)
//           op_ready/op_len                  - decoder consume handshake
//           op_valid/op1..3/op_pc            - opcode window to decoder
// Revision: 1.0 - initial release
// ============================================================================
module oc8051_op_fetch
  import oc8051_fetch_pkg::*;
#(
  parameter int INT_ROM_WID = DEF_INT_ROM_WID
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rom_addr,
  input  logic        rom_ea_int,
  input  logic [7:0]  rom_data1,
  input  logic [7:0]  rom_data2,
  input  logic [7:0]  rom_data3,
  output logic        ext_req,
  output logic [15:0] ext_addr,
  input  logic        ext_ack,
  input  logic [7:0]  ext_data,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  input  logic        op_ready,
  input  logic [1:0]  op_len,
  output logic        op_valid,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [7:0]  op3,
  output logic [15:0] op_pc
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [15:0] r_pc;
  logic        r_op_valid;
  logic [7:0]  r_op1;
  logic [7:0]  r_op2;
  logic [7:0]  r_op3;
  logic [15:0] r_op_pc;

  logic [15:0] w_pc_plus2;
  logic        w_int_win;
  logic        w_ext_start;
  logic        w_rom_load;
  logic        w_ext_abort;
  logic        w_ext_done;
  logic        w_ext_drop;
  logic [7:0]  w_ext_b0;
  logic [7:0]  w_ext_b1;

  // The PC register itself addresses the ROM, so in ISSUE the ROM is already
  // looking at the current PC and its data is ready one cycle later.
  assign rom_addr = r_pc;

  // The whole window must fit in internal ROM; a straddling window goes out.
  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_int_win  = rom_ea_int && (w_pc_plus2[15:INT_ROM_WID] == '0);

  assign w_ext_abort = pc_load && (state == ST_EXT);

  oc8051_ext_byte_rd u_ext_rd (
    .clk       (clk),
    .rst       (rst),
    .start     (w_ext_start),
    .base_addr (r_pc),
    .abort     (w_ext_abort),
    .ext_req   (ext_req),
    .ext_addr  (ext_addr),
    .ext_ack   (ext_ack),
    .ext_data  (ext_data),
    .byte0     (w_ext_b0),
    .byte1     (w_ext_b1),
    .done      (w_ext_done),
    .drop      (w_ext_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_ISSUE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    w_ext_start = 1'b0;
    w_rom_load  = 1'b0;
    case (state)
      ST_ISSUE: begin
        if (!pc_load) begin
          if (w_int_win) begin
            state_nxt = ST_ROM_WAIT;
          end else begin
            state_nxt   = ST_EXT;
            w_ext_start = 1'b1;
          end
        end
      end
      ST_ROM_WAIT: begin
        if (pc_load) begin
          state_nxt = ST_ISSUE;
        end else begin
          w_rom_load = 1'b1;
          state_nxt  = ST_VALID;
        end
      end
      ST_EXT: begin
        // A reload stays here until the outstanding byte is acked.
        if (w_ext_drop)      state_nxt = ST_ISSUE;
        else if (w_ext_done) state_nxt = ST_VALID;
      end
      ST_VALID: begin
        if (pc_load || op_ready) state_nxt = ST_ISSUE;
      end
      default: state_nxt = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= 16'h0000;
      r_op_valid <= 1'b0;
      r_op1      <= 8'h00;
      r_op2      <= 8'h00;
      r_op3      <= 8'h00;
      r_op_pc    <= 16'h0000;
    end else begin
      if (pc_load) begin
        r_pc       <= pc_in;
        r_op_valid <= 1'b0;
      end else if ((state == ST_VALID) && op_ready) begin
        r_pc       <= r_pc + op_len_dec(op_len);
        r_op_valid <= 1'b0;
      end
      if (w_rom_load) begin
        r_op1      <= rom_data1;
        r_op2      <= rom_data2;
        r_op3      <= rom_data3;
        r_op_pc    <= r_pc;
        r_op_valid <= 1'b1;
      end
      if (w_ext_done) begin
        r_op1      <= w_ext_b0;
        r_op2      <= w_ext_b1;
        r_op3      <= ext_data;
        r_op_pc    <= r_pc;
        r_op_valid <= 1'b1;
      end
    end
  end

  assign op_valid = r_op_valid;
  assign op1      = r_op1;
  assign op2      = r_op2;
  assign op3      = r_op3;
  assign op_pc    = r_op_pc;

endmodule
`default_nettype wire
